// File: rtl/regfile8x8_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared definitions for the regfile8x8 write-port controller:
//   - state_e      : sequencer states (clearing the file, then normal traffic)
//   - REQ_A/REQ_B  : encoding of the round-robin last-grant pointer
//   - CLR_DATA     : value written to every register during clearing
package regfile_ctrl_pkg;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Wide enough for any sensible data width; users slice [DW-1:0].
  localparam logic [63:0] CLR_DATA = '0;

endpackage

// File: rtl/regfile8x8_ctrl_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The caller owns the
// pointer register and loads ptr_nxt on the edge that issues the grant.
//   req[1:0]  in   request vector, bit 0 = A, bit 1 = B
//   ptr       in   last-granted requester (REQ_A / REQ_B)
//   gnt[1:0]  out  one-hot grant (or zero when nothing requests)
//   ptr_nxt   out  pointer value after this grant
import regfile_ctrl_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    if (req == 2'b11) begin
      // Tie: the requester that did not win last time goes first.
      gnt = (ptr == REQ_B) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (gnt[0]) begin
      ptr_nxt = REQ_A;
    end else if (gnt[1]) begin
      ptr_nxt = REQ_B;
    end
  end

endmodule

// File: rtl/regfile8x8_ctrl.sv
// regfile8x8_ctrl
// Write-port arbiter and initialisation sequencer for the regfile8x8
// register file. After every reset it writes zero to all 2^AW registers,
// then shares the single write port between requesters A and B with a
// round-robin req/grant handshake. Each requester has its own read port.
//   clk, rst_n                      clock, async active-low reset
//   a_wreq/a_waddr/a_wdata/a_wgnt   requester A write handshake
//   b_wreq/b_waddr/b_wdata/b_wgnt   requester B write handshake
//   a_raddr/a_rdata                 A read port (regfile port 1)
//   b_raddr/b_rdata                 B read port (regfile port 2)
//   init_done                       high once clearing has finished
//   rf_we3/rf_wa3/rf_wd3            registered regfile write port
//   rf_ra1/rf_ra2, rf_rd1/rf_rd2    regfile read ports (pass-through)
import regfile_ctrl_pkg::*;

module regfile8x8_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_wreq,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_wgnt,
  input  logic          b_wreq,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_wgnt,
  input  logic [AW-1:0] a_raddr,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_raddr,
  output logic [DW-1:0] b_rdata,
  output logic          init_done,
  output logic          rf_we3,
  output logic [AW-1:0] rf_wa3,
  output logic [DW-1:0] rf_wd3,
  output logic [AW-1:0] rf_ra1,
  output logic [AW-1:0] rf_ra2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_END = {1'b1, {AW{1'b0}}};

  state_e      state;
  logic [AW:0] cnt;
  logic [AW:0] cnt_nxt;
  logic        ptr;
  logic        ptr_nxt;
  logic [1:0]  elig;
  logic [1:0]  gnt;

  // Read ports are straight wires; no write-to-read bypass.
  assign rf_ra1  = a_raddr;
  assign a_rdata = rf_rd1;
  assign rf_ra2  = b_raddr;
  assign b_rdata = rf_rd2;

  // A requester whose grant is showing this cycle is being consumed and
  // still holds its request, so it must not be granted a second time.
  assign elig    = {b_wreq & ~b_wgnt, a_wreq & ~a_wgnt};
  assign cnt_nxt = cnt + CNT_ONE;

  rr_arb2 u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      ptr       <= REQ_B;
      init_done <= 1'b0;
      a_wgnt    <= 1'b0;
      b_wgnt    <= 1'b0;
      rf_we3    <= 1'b0;
      rf_wa3    <= '0;
      rf_wd3    <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          // One clear write per edge; requests wait until S_RUN.
          rf_we3 <= 1'b1;
          rf_wa3 <= cnt[AW-1:0];
          rf_wd3 <= CLR_DATA[DW-1:0];
          a_wgnt <= 1'b0;
          b_wgnt <= 1'b0;
          cnt    <= cnt_nxt;
          // Leave as the last address is being presented, so the first
          // grant can be issued on the very next edge.
          if (cnt_nxt == CNT_END) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          init_done <= 1'b1;
          a_wgnt    <= gnt[0];
          b_wgnt    <= gnt[1];
          rf_we3    <= |gnt;
          ptr       <= ptr_nxt;
          // Address/data hold when idle; only rf_we3 qualifies them.
          if (gnt[0]) begin
            rf_wa3 <= a_waddr;
            rf_wd3 <= a_wdata;
          end else if (gnt[1]) begin
            rf_wa3 <= b_waddr;
            rf_wd3 <= b_wdata;
          end
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile8x8_ctrl.sv
module tb_regfile8x8_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_wreq = 1'b0, b_wreq = 1'b0;
  logic [AW-1:0] a_waddr = '0, b_waddr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_wgnt, b_wgnt;
  logic [AW-1:0] a_raddr = '0, b_raddr = '0;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          init_done;
  logic          rf_we3;
  logic [AW-1:0] rf_wa3, rf_ra1, rf_ra2;
  logic [DW-1:0] rf_wd3, rf_rd1, rf_rd2;

  regfile8x8_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wreq(a_wreq), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wgnt(a_wgnt),
    .b_wreq(b_wreq), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_wgnt(b_wgnt),
    .a_raddr(a_raddr), .a_rdata(a_rdata), .b_raddr(b_raddr), .b_rdata(b_rdata),
    .init_done(init_done),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  always #5 clk = ~clk;

  // The attached register file: no reset, write at edge, async read.
  logic [DW-1:0] rf_mem [8];
  always @(posedge clk) if (rf_we3) rf_mem[rf_wa3] <= rf_wd3;
  assign rf_rd1 = rf_mem[rf_ra1];
  assign rf_rd2 = rf_mem[rf_ra2];

  // Reference model: what each register should hold.
  logic [DW-1:0] ref_mem [8];

  typedef struct { logic [AW-1:0] ad; logic [DW-1:0] d; } wr_t;
  typedef struct { logic port; logic [AW-1:0] ad; logic [DW-1:0] exp; } rd_t;
  wr_t a_q[$];
  wr_t b_q[$];
  rd_t rd_q[$];
  int  clr_q[$];
  int  g_who[$];
  int  g_cyc[$];
  bit  log_en = 1'b0;
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant, a clear
  // write or a pending read.
  wr_t mw;
  rd_t mr;
  int  mc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_wgnt || b_wgnt) check("gnt_mutex", int'(a_wgnt & b_wgnt), 0);
      if (a_wgnt) begin
        if (a_q.size() == 0) check("a_unexpected_gnt", 1, 0);
        else begin
          mw = a_q.pop_front();
          check("a_we", int'(rf_we3), 1);
          check("a_wa", int'(rf_wa3), int'(mw.ad));
          check("a_wd", int'(rf_wd3), int'(mw.d));
        end
        if (log_en) begin g_who.push_back(0); g_cyc.push_back(cyc); end
      end
      if (b_wgnt) begin
        if (b_q.size() == 0) check("b_unexpected_gnt", 1, 0);
        else begin
          mw = b_q.pop_front();
          check("b_we", int'(rf_we3), 1);
          check("b_wa", int'(rf_wa3), int'(mw.ad));
          check("b_wd", int'(rf_wd3), int'(mw.d));
        end
        if (log_en) begin g_who.push_back(1); g_cyc.push_back(cyc); end
      end
      if (init_done && !a_wgnt && !b_wgnt) check("idle_we", int'(rf_we3), 0);
      if (!init_done && rf_we3) begin
        if (clr_q.size() == 0) check("clr_extra", 1, 0);
        else begin
          mc = clr_q.pop_front();
          check("clr_wa", int'(rf_wa3), mc);
          check("clr_wd", int'(rf_wd3), 0);
        end
      end
      while (rd_q.size() > 0) begin
        mr = rd_q.pop_front();
        if (mr.port) check("b_rdata", int'(b_rdata), int'(mr.exp));
        else         check("a_rdata", int'(a_rdata), int'(mr.exp));
      end
    end
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    a_wreq = 1'b0;
    b_wreq = 1'b0;
    a_q.delete(); b_q.delete(); clr_q.delete();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) clr_q.push_back(i);
    rst_n = 1'b1;
  endtask

  // Walks edges 1..9 after release; optionally raises an A request during
  // the clear that must not be granted until edge 9.
  task automatic wait_init(input bit req_test);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      check("init_done", int'(init_done), int'(e == 9));
      if (e <= 8) check("clr_we", int'(rf_we3), 1);
      if (req_test) begin
        if (e == 1) begin
          a_waddr = 3'd5; a_wdata = 8'h55; a_wreq = 1'b1;
          a_q.push_back(wr_t'{3'd5, 8'h55});
        end else begin
          check("clr_gnt", int'(a_wgnt), int'(e == 9));
        end
      end
    end
    if (req_test) begin
      @(posedge clk);
      #1;
      a_wreq = 1'b0;
      ref_mem[5] = 8'h55;
    end
  endtask

  task automatic wr(input bit p, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                    input bit chk_lat);
    int  n = 0;
    bit  g = 1'b0;
    if (!p) begin a_waddr = ad; a_wdata = d; a_wreq = 1'b1; a_q.push_back(wr_t'{ad, d}); end
    else    begin b_waddr = ad; b_wdata = d; b_wreq = 1'b1; b_q.push_back(wr_t'{ad, d}); end
    do begin
      @(posedge clk);
      #1;
      n++;
      g = p ? b_wgnt : a_wgnt;
    end while (!g && n < 20);
    if (!g) begin
      check(p ? "b_gnt_timeout" : "a_gnt_timeout", 0, 1);
    end else begin
      if (chk_lat) check(p ? "b_lat_le2" : "a_lat_le2", int'(n <= 2), 1);
      @(posedge clk);
      #1;
      ref_mem[ad] = d;
    end
    if (!p) a_wreq = 1'b0; else b_wreq = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
    a_raddr = aa;
    b_raddr = ba;
    rd_q.push_back(rd_t'{1'b0, aa, ref_mem[aa]});
    rd_q.push_back(rd_t'{1'b1, ba, ref_mem[ba]});
    @(posedge clk);
    #1;
  endtask

  task automatic dump();
    for (int i = 0; i < 8; i++) rd(3'(i), 3'((i + 1) % 8));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, clear sequence and all-zero dump.
    do_reset();
    check("rst_init_done", int'(init_done), 0);
    wait_init(1'b0);
    dump();

    // Request raised during clearing.
    do_reset();
    wait_init(1'b1);
    rd(3'd5, 3'd5);

    // Both requesters continuous: strict A/B alternation.
    do_reset();
    wait_init(1'b0);
    g_who.delete(); g_cyc.delete();
    log_en = 1'b1;
    fork
      for (int i = 0; i < 4; i++) wr(1'b0, 3'(2 * i), 8'(16 * (2 * i)), 1'b1);
      for (int i = 0; i < 4; i++) wr(1'b1, 3'(2 * i + 1), 8'(16 * (2 * i + 1)), 1'b1);
    join
    log_en = 1'b0;
    check("alt_count", g_who.size(), 8);
    for (int i = 0; i < g_who.size(); i++) begin
      check("alt_who", g_who[i], i % 2);
      check("alt_cyc", g_cyc[i] - g_cyc[0], i);
    end
    dump();

    // A alone: one grant every other cycle.
    g_who.delete(); g_cyc.delete();
    log_en = 1'b1;
    wr(1'b0, 3'd1, 8'h11, 1'b1);
    wr(1'b0, 3'd2, 8'h22, 1'b1);
    wr(1'b0, 3'd3, 8'h33, 1'b1);
    log_en = 1'b0;
    check("solo_count", g_cyc.size(), 3);
    for (int i = 1; i < g_cyc.size(); i++) check("solo_gap", g_cyc[i] - g_cyc[i-1], 2);
    rd(3'd1, 3'd2);
    rd(3'd3, 3'd3);

    // Randomised traffic from both sides.
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        wr(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'b1);
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        wr(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'b1);
      end
    join
    dump();

    // Reset while a write of 0x44 to address 4 is on the port.
    a_waddr = 3'd4; a_wdata = 8'h44; a_wreq = 1'b1;
    a_q.push_back(wr_t'{3'd4, 8'h44});
    begin
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!a_wgnt && n < 20);
      check("pre_rst_gnt", int'(a_wgnt), 1);
      check("pre_rst_we", int'(rf_we3), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("async_we", int'(rf_we3), 0);
    check("async_gnt", int'(a_wgnt), 0);
    check("async_wa", int'(rf_wa3), 0);
    check("async_done", int'(init_done), 0);
    do_reset();
    wait_init(1'b0);
    rd(3'd4, 3'd4);
    dump();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
